// File: rtl/sys_timer_sequencer_pkg.sv
// sys_timer_pkg: timer register map, control codes, sequencer states and bus helpers (snapshot states under SYS_TIMER_SEQ_SNAP_EN)
package sys_timer_pkg;
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL = 3'd1;
  localparam logic [2:0] ADDR_PERL = 3'd2;
  localparam logic [2:0] ADDR_PERH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL = 3'd4;
  localparam logic [2:0] ADDR_SNAPH = 3'd5;
  localparam int CTRL_ITO = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOPB = 3;
  localparam logic [3:0] CTRL_RUN = 4'h7;
  localparam logic [3:0] CTRL_STOP = 4'h8;
  typedef enum logic [3:0] {
    IDLE, PRG_STOP, PRG_PL, PRG_PH, PRG_CTRL, RUN, CLR, STOP
`ifdef SYS_TIMER_SEQ_SNAP_EN
    , SNP_WR, SNP_RL, SNP_RH, SNP_CAP
`endif
  } state_t;
  typedef struct packed {
    logic [2:0] addr;
    logic cs;
    logic wn;
    logic [15:0] wd;
  } bus_t;
  localparam bus_t BUS_IDLE = '{addr: 3'd0, cs: 1'b0, wn: 1'b1, wd: 16'd0};
  function automatic bus_t bus_wr(input logic [2:0] a, input logic [15:0] d);
    return '{addr: a, cs: 1'b1, wn: 1'b0, wd: d};
  endfunction
  function automatic bus_t bus_rd(input logic [2:0] a);
    return '{addr: a, cs: 1'b1, wn: 1'b1, wd: 16'd0};
  endfunction
endpackage

// File: rtl/sys_timer_sequencer_if.sv
// sys_timer_sequencer_if: Avalon-MM link between the sequencer (master) and the interval timer (slave)
interface sys_timer_sequencer_if;
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/sys_timer_sequencer.sv
// sys_timer_sequencer: programs, runs, services and snapshots the interval timer; snapshot path built only with SYS_TIMER_SEQ_SNAP_EN
module sys_timer_sequencer import sys_timer_pkg::*; #(
  parameter int TICK_W = 32,
  parameter int INIT_PERIOD = 49999,
  parameter bit AUTO_START = 1'b0
) (
  input logic clk,
  input logic reset_n,
  input logic [31:0] cfg_period,
  input logic cfg_start,
  input logic cfg_stop,
  input logic snap_req,
  output logic busy,
  output logic running,
  output logic tick,
  output logic [TICK_W-1:0] tick_count,
  output logic cfg_err,
  output logic snap_valid,
  output logic [31:0] snap_value,
  sys_timer_sequencer_if.master tmr
);
  state_t state, state_n;
  bus_t bus_q, bus_n;
  logic start_p, stop_p, auto_done;
  logic start_acc, start_any, stop_any, snap_any, auto_go, serve;
  logic [31:0] per_p, prog;
  // request qualification and next-state selection; RUN order is irq, stop, snapshot, restart
  always_comb begin
    start_acc = cfg_start & ~cfg_stop & ~start_p & (cfg_period != 32'd0);
    start_any = start_p | start_acc;
    stop_any = stop_p | (cfg_stop & (state != IDLE));
    auto_go = AUTO_START & ~auto_done;
    state_n = state;
    case (state)
      IDLE: state_n = (auto_go | start_any) ? PRG_STOP : IDLE;
      PRG_STOP: state_n = PRG_PL;
      PRG_PL: state_n = PRG_PH;
      PRG_PH: state_n = PRG_CTRL;
      PRG_CTRL: state_n = RUN;
`ifdef SYS_TIMER_SEQ_SNAP_EN
      RUN: state_n = tmr.irq ? CLR : stop_any ? STOP : snap_any ? SNP_WR : start_any ? PRG_STOP : RUN;
      SNP_WR: state_n = SNP_RL;
      SNP_RL: state_n = SNP_RH;
      SNP_RH: state_n = SNP_CAP;
      SNP_CAP: state_n = RUN;
`else
      RUN: state_n = tmr.irq ? CLR : stop_any ? STOP : start_any ? PRG_STOP : RUN;
`endif
      CLR: state_n = RUN;
      STOP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    serve = (state == IDLE || state == RUN) && state_n == PRG_STOP;
  end
  // bus cycle for the state being entered, so the registered bus lines up with the state
  always_comb begin
    case (state_n)
      PRG_STOP, STOP: bus_n = bus_wr(ADDR_CTRL, {12'd0, CTRL_STOP});
      PRG_PL: bus_n = bus_wr(ADDR_PERL, prog[15:0]);
      PRG_PH: bus_n = bus_wr(ADDR_PERH, prog[31:16]);
      PRG_CTRL: bus_n = bus_wr(ADDR_CTRL, {12'd0, CTRL_RUN});
      CLR: bus_n = bus_wr(ADDR_STATUS, 16'd0);
`ifdef SYS_TIMER_SEQ_SNAP_EN
      SNP_WR: bus_n = bus_wr(ADDR_SNAPL, 16'd0);
      SNP_RL: bus_n = bus_rd(ADDR_SNAPL);
      SNP_RH: bus_n = bus_rd(ADDR_SNAPH);
`endif
      default: bus_n = BUS_IDLE;
    endcase
  end
  // state, pending requests, latched period, tick counter and bus register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      start_p <= 1'b0;
      stop_p <= 1'b0;
      auto_done <= 1'b0;
      per_p <= '0;
      prog <= '0;
      tick_count <= '0;
      cfg_err <= 1'b0;
      bus_q <= BUS_IDLE;
    end else begin
      state <= state_n;
      start_p <= start_any & ~serve;
      stop_p <= stop_any & (state_n != STOP) & (state_n != IDLE);
      if (start_acc) per_p <= cfg_period;
      if (serve) prog <= auto_go ? 32'(INIT_PERIOD) : start_p ? per_p : cfg_period;
      if (state != IDLE) auto_done <= 1'b1;
      tick_count <= (state == PRG_CTRL) ? '0 : (state == CLR) ? tick_count + TICK_W'(1) : tick_count;
      cfg_err <= cfg_start & ~cfg_stop & (cfg_period == 32'd0);
      bus_q <= bus_n;
    end
  assign busy = (state != IDLE) && (state != RUN);
  assign running = state == RUN;
  assign tick = state == CLR;
  assign tmr.address = bus_q.addr;
  assign tmr.chipselect = bus_q.cs;
  assign tmr.write_n = bus_q.wn;
  assign tmr.writedata = bus_q.wd;
`ifdef SYS_TIMER_SEQ_SNAP_EN
  logic snap_p;
  logic [15:0] snap_lo;
  assign snap_any = snap_p | (snap_req & (state != IDLE));
  // snapshot request holding and low-half capture; high half arrives during SNP_CAP
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      snap_p <= 1'b0;
      snap_lo <= '0;
    end else begin
      snap_p <= snap_any & (state_n != SNP_WR) & (state_n != IDLE);
      if (state == SNP_RH) snap_lo <= tmr.readdata;
    end
  assign snap_valid = state == SNP_CAP;
  assign snap_value = snap_valid ? {tmr.readdata, snap_lo} : 32'd0;
`else
  logic unused_ok;
  assign snap_any = 1'b0;
  assign unused_ok = ^{snap_req, tmr.readdata, snap_any};
  assign snap_valid = 1'b0;
  assign snap_value = 32'd0;
`endif
endmodule
